bus_change_logger: RTL and testbench
====================================

# bus_change_logger

Synthesizable on-chip activity recorder for SoC bring-up. It watches a WIDTH-bit status bus, such as the picosoc LED port, and reports progress in hardware instead of through a simulation-only bench:
- **Change logging:** each settled value change is timestamped with a free-running cycle count and queued in a DEPTH-entry FIFO.
- **Progress ticks:** a tick pulses every INTERVAL cycles.
- **Run length:** recording stops after NUM_INTERVALS ticks.

The FIFO is drained through a valid/ready port by a UART or debug bridge.

## Interface
- WIDTH, 8, monitored bus width (1..32)
- DEPTH, 16, FIFO entries; power of two, at least 2
- TS_WIDTH, 32, timestamp / cycle-counter width
- INTERVAL, 50000, cycles per progress tick (at least 2)
- NUM_INTERVALS, 10, ticks after which the run ends (at least 1)
- SETTLE, 1, consecutive samples a new value must hold before it is logged (at least 1)

- clk  in  1  single clock; all logic on the rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run (flushes FIFO, clears counters)
- mon_in  in  WIDTH  monitored bus, synchronous to clk
- rd_valid  out  1  FIFO head entry available
- rd_ready  in  1  consumer accepts head entry
- rd_data  out  WIDTH  logged bus value
- rd_ts  out  TS_WIDTH  cycle count at push
- tick  out  1  one-cycle pulse per completed interval
- intervals  out  $clog2(NUM_INTERVALS+1)  completed-interval count
- running  out  1  state is RUN
- done  out  1  state is DONE
- overflow  out  1  sticky: an event was dropped because the FIFO was full

## Operation
- **States** (IDLE, RUN, DONE):
  - IDLE→RUN on start.
  - RUN→DONE on the cycle the NUM_INTERVALS-th tick fires.
  - DONE→RUN on start.
  - start in RUN restarts the run (same actions as entering RUN).
- **Entering RUN:**
  - FIFO emptied.
  - cycle_cnt, interval_cnt, intervals, stable_cnt and overflow cleared.
  - have_logged cleared, so the first settled value is always logged.
- **Cycle counting in RUN:**
  - cycle_cnt increments every cycle and wraps modulo 2^TS_WIDTH.
  - interval_cnt counts 0..INTERVAL-1.
  - When interval_cnt = INTERVAL-1, tick pulses and intervals increments.
- **Change filter:**
  - mon_in is registered into samp every cycle.
  - stable_cnt resets to 1 when samp ≠ mon_in, else saturates at SETTLE.
  - Push when running, stable_cnt = SETTLE, and (samp ≠ last_logged or !have_logged).
  - A push writes {samp, cycle_cnt} and updates last_logged and have_logged.
  - Glitches shorter than SETTLE samples are never logged.
- **FIFO:**
  - First-word-fall-through; rd_data/rd_ts are valid whenever rd_valid is high.
  - A pop occurs when rd_valid && rd_ready.
  - Push while full with no pop in the same cycle: the entry is dropped, overflow is set and last_logged is not updated, so the change is retried next cycle.
  - Push and pop in the same cycle when full: both succeed.
  - Pop in IDLE/DONE remains allowed, so the log is drained after the run.
- **DONE:** counters frozen, no pushes, tick low.

## Timing
- **Reset:** all outputs 0, state IDLE, FIFO empty, samp=0.
- **start:** if start is sampled at edge k, running=1 after edge k and cycle_cnt=0 in the following cycle.
- **Push latency:** a mon_in value first present at edge k is pushed at edge k+SETTLE. rd_valid rises after that edge if the FIFO was empty.
- **First tick:** tick is high in the cycle where cycle_cnt = INTERVAL-1, mod 2^TS_WIDTH.
- **done:** asserts the cycle after the final tick.
- **Simultaneous final tick and push:** the push is still accepted.
- **start and pop in the same cycle:** start wins; the FIFO is emptied.
- **Reset mid-run:** immediate return to IDLE; FIFO contents are lost.

## Structure
- Package bus_change_logger_pkg holds:
  - state enum (IDLE/RUN/DONE)
  - log_entry_t struct {data, ts}, parameterised through localparam widths
- Sub-module sync_fifo_fwft(DEPTH, entry width):
  - ptr-plus-wrap-bit full/empty logic
  - synchronous flush input
- Top holds the FSM, counters and change filter.

## Test plan
- **Initial value:** reset, mon_in=8'h00, start, SETTLE=1 → one entry {00, ts=1}; nothing further while mon_in is stable.
- **Change and glitch filter:** mon_in 00→A5 held 5 cycles, then a one-cycle 3C glitch, with SETTLE=2 → exactly one new entry {A5, ts = change cycle+2}; no 3C entry.
- **Overflow:** DEPTH=4, rd_ready=0, 6 distinct settled changes → 4 entries, overflow=1. Raise rd_ready → first 4 values are read in order and the retried change is then logged.
- **Progress ticks and end of run:** INTERVAL=10, NUM_INTERVALS=3 → tick at cycle_cnt 9, 19, 29; intervals=3; done=1 from the next cycle; later mon_in changes are ignored while the FIFO still drains.
- **Restart and reset:** start during RUN with 2 entries queued → FIFO empty, counters 0. resetn low mid-run → all outputs 0 asynchronously; state IDLE on release.

Source files
------------

// File: rtl/bus_change_logger_pkg.sv
// Shared types for bus_change_logger.
//   state_t     : run-control state (IDLE / RUN / DONE)
//   log_entry_t : one log record {data, ts} at the default widths; the top
//                 builds the same {data, ts} layout at its own parameter widths.
package bus_change_logger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int LOG_DATA_W = 8;
  localparam int LOG_TS_W   = 32;

  typedef struct packed {
    logic [LOG_DATA_W-1:0] data;
    logic [LOG_TS_W-1:0]   ts;
  } log_entry_t;

endpackage

// File: rtl/bus_change_logger_fifo.sv
// First-word-fall-through synchronous FIFO used as the change log.
//   clk, resetn        : clock, asynchronous active-low reset
//   flush              : synchronous empty; overrides push and pop that cycle
//   wr_en, wr_data     : push request and entry (dropped when full without pop)
//   rd_en              : pop request (ignored when empty)
//   rd_valid, rd_data  : head entry, zero while empty
//   full               : no free slot
module sync_fifo_fwft #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 40
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic               empty;
  logic               do_wr;
  logic               do_rd;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd = rd_en && !empty && !flush;
    // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
    do_wr = wr_en && (!full || do_rd) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    rd_valid = !empty;
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage holds no control state, so it is left unreset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/bus_change_logger.sv
// On-chip activity recorder: logs timestamped, settled changes of a status
// bus into a FWFT FIFO, pulses a progress tick every INTERVAL cycles and ends
// the run after NUM_INTERVALS ticks.
//   clk, resetn                 : clock, asynchronous active-low reset
//   start                       : begin / restart a run (flushes log, clears counters)
//   mon_in                      : monitored bus
//   rd_valid/rd_ready           : log drain handshake
//   rd_data, rd_ts              : head entry value and push-time cycle count
//   tick, intervals             : progress pulse and completed-interval count
//   running, done, overflow     : state flags and sticky drop indicator
module bus_change_logger
  import bus_change_logger_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int TS_WIDTH      = 32,
  parameter int INTERVAL      = 50000,
  parameter int NUM_INTERVALS = 10,
  parameter int SETTLE        = 1
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               start,
  input  logic [WIDTH-1:0]                   mon_in,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [WIDTH-1:0]                   rd_data,
  output logic [TS_WIDTH-1:0]                rd_ts,
  output logic                               tick,
  output logic [$clog2(NUM_INTERVALS+1)-1:0] intervals,
  output logic                               running,
  output logic                               done,
  output logic                               overflow
);

  localparam int IV_W = $clog2(NUM_INTERVALS+1);
  localparam int IC_W = $clog2(INTERVAL);
  localparam int ST_W = $clog2(SETTLE+1);

  typedef struct packed {
    logic [WIDTH-1:0]    data;
    logic [TS_WIDTH-1:0] ts;
  } entry_t;

  state_t              state_q, state_d;
  logic [TS_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [IC_W-1:0]     interval_cnt_q, interval_cnt_d;
  logic [IV_W-1:0]     intervals_q, intervals_d;
  logic [ST_W-1:0]     stable_cnt_q, stable_cnt_d;
  logic [WIDTH-1:0]    samp_q, samp_d;
  logic [WIDTH-1:0]    last_logged_q, last_logged_d;
  logic                have_logged_q, have_logged_d;
  logic                overflow_q, overflow_d;

  logic   in_run;
  logic   tick_c;
  logic   push_req;
  logic   push_ok;
  logic   pop;
  logic   fifo_full;
  entry_t wr_entry;
  entry_t rd_entry;

  always_comb begin
    in_run   = (state_q == ST_RUN);
    tick_c   = in_run && (interval_cnt_q == IC_W'(INTERVAL-1));
    push_req = in_run && (stable_cnt_q == ST_W'(SETTLE))
               && ((samp_q != last_logged_q) || !have_logged_q);
    pop      = rd_valid && rd_ready;
    push_ok  = push_req && (!fifo_full || pop);
    wr_entry = '{data: samp_q, ts: cycle_cnt_q};

    state_d        = state_q;
    cycle_cnt_d    = cycle_cnt_q;
    interval_cnt_d = interval_cnt_q;
    intervals_d    = intervals_q;
    stable_cnt_d   = stable_cnt_q;
    samp_d         = mon_in;
    last_logged_d  = last_logged_q;
    have_logged_d  = have_logged_q;
    overflow_d     = overflow_q;

    if (samp_q != mon_in) begin
      stable_cnt_d = ST_W'(1);
    end else if (stable_cnt_q != ST_W'(SETTLE)) begin
      stable_cnt_d = stable_cnt_q + ST_W'(1);
    end

    if (start) begin
      state_d        = ST_RUN;
      cycle_cnt_d    = '0;
      interval_cnt_d = '0;
      intervals_d    = '0;
      stable_cnt_d   = '0;
      overflow_d     = 1'b0;
      have_logged_d  = 1'b0;
    end else if (in_run) begin
      cycle_cnt_d = cycle_cnt_q + TS_WIDTH'(1);
      if (tick_c) begin
        interval_cnt_d = '0;
        intervals_d    = intervals_q + IV_W'(1);
        if (intervals_q == IV_W'(NUM_INTERVALS-1)) state_d = ST_DONE;
      end else begin
        interval_cnt_d = interval_cnt_q + IC_W'(1);
      end
      // A dropped push leaves last_logged alone so the change is retried.
      if (push_ok) begin
        last_logged_d = samp_q;
        have_logged_d = 1'b1;
      end else if (push_req) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      cycle_cnt_q    <= '0;
      interval_cnt_q <= '0;
      intervals_q    <= '0;
      stable_cnt_q   <= '0;
      samp_q         <= '0;
      last_logged_q  <= '0;
      have_logged_q  <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cycle_cnt_q    <= cycle_cnt_d;
      interval_cnt_q <= interval_cnt_d;
      intervals_q    <= intervals_d;
      stable_cnt_q   <= stable_cnt_d;
      samp_q         <= samp_d;
      last_logged_q  <= last_logged_d;
      have_logged_q  <= have_logged_d;
      overflow_q     <= overflow_d;
    end
  end

  // start flushes the log and takes priority over a same-cycle pop or push.
  sync_fifo_fwft #(
    .DEPTH   (DEPTH),
    .ENTRY_W ($bits(entry_t))
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (start),
    .wr_en    (push_ok),
    .wr_data  (wr_entry),
    .rd_en    (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_entry),
    .full     (fifo_full)
  );

  assign rd_data   = rd_entry.data;
  assign rd_ts     = rd_entry.ts;
  assign tick      = tick_c;
  assign intervals = intervals_q;
  assign running   = in_run;
  assign done      = (state_q == ST_DONE);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_bus_change_logger.sv
module tb_bus_change_logger;

  localparam int WIDTH         = 8;
  localparam int DEPTH         = 4;
  localparam int TS_WIDTH      = 16;
  localparam int INTERVAL      = 20;
  localparam int NUM_INTERVALS = 3;
  localparam int SETTLE        = 2;
  localparam int IV_W          = $clog2(NUM_INTERVALS+1);

  logic                clk = 1'b0;
  logic                resetn;
  logic                start;
  logic [WIDTH-1:0]    mon_in;
  logic                rd_valid;
  logic                rd_ready;
  logic [WIDTH-1:0]    rd_data;
  logic [TS_WIDTH-1:0] rd_ts;
  logic                tick;
  logic [IV_W-1:0]     intervals;
  logic                running;
  logic                done;
  logic                overflow;

  int total = 0;
  int bad   = 0;
  int t     = 0;   // expected DUT cycle_cnt since the last start

  always #5 clk = ~clk;

  bus_change_logger #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH),
    .INTERVAL(INTERVAL), .NUM_INTERVALS(NUM_INTERVALS), .SETTLE(SETTLE)
  ) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .mon_in(mon_in),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_ts(rd_ts),
    .tick(tick), .intervals(intervals), .running(running), .done(done),
    .overflow(overflow)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic step_to(input int target);
    while (t < target) step(1);
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
    t = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b1; start = 1'b0; mon_in = 8'h00; rd_ready = 1'b0;
    #1 resetn = 1'b0;
    #1;
    total++; if ({rd_valid, tick, running, done, overflow} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {rd_valid, tick, running, done, overflow}); end
    total++; if (rd_data !== 8'h00 || rd_ts !== 16'h0) begin bad++; $display("FAIL reset_rd: got %h/%h want 00/0000", rd_data, rd_ts); end
    total++; if (intervals !== 2'd0) begin bad++; $display("FAIL reset_intervals: got %0d want 0", intervals); end
    step(2);
    resetn = 1'b1;
    step(2);
    total++; if (running !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL reset_idle: got running=%b valid=%b want 0 0", running, rd_valid); end
  endtask

  task automatic test_initial_value();
    do_start();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL init_running: got %b want 1", running); end
    step_to(2);
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL init_early: got valid=%b want 0", rd_valid); end
    step_to(3);
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h00 || rd_ts !== 16'd2) begin bad++; $display("FAIL init_entry: got %b {%h,%0d} want 1 {00,2}", rd_valid, rd_data, rd_ts); end
    step_to(8);
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL init_single: got valid=%b want 0", rd_valid); end
  endtask

  task automatic test_change_glitch();
    do_start();
    step_to(3);  mon_in = 8'hA5;
    step_to(8);  mon_in = 8'h3C;
    step(1);     mon_in = 8'hA5;
    step_to(14);
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h00 || rd_ts !== 16'd2) begin bad++; $display("FAIL glitch_e0: got %b {%h,%0d} want 1 {00,2}", rd_valid, rd_data, rd_ts); end
    rd_ready = 1'b1;
    step(1);
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || rd_ts !== 16'd5) begin bad++; $display("FAIL glitch_e1: got %b {%h,%0d} want 1 {a5,5}", rd_valid, rd_data, rd_ts); end
    step(1);
    rd_ready = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL glitch_none: got valid=%b data=%h want 0", rd_valid, rd_data); end
  endtask

  task automatic test_overflow();
    do_start();                       // mon_in is A5
    step_to(3);  mon_in = 8'h11;
    step_to(6);  mon_in = 8'h22;
    step_to(9);  mon_in = 8'h33;
    step_to(12); mon_in = 8'h44;
    step_to(14);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
    step(1);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
    mon_in = 8'h55;
    step_to(18);
    total++; if (rd_data !== 8'hA5 || rd_ts !== 16'd2) begin bad++; $display("FAIL ovf_e0: got {%h,%0d} want {a5,2}", rd_data, rd_ts); end
    rd_ready = 1'b1;
    step(1);
    total++; if (rd_data !== 8'h11 || rd_ts !== 16'd5) begin bad++; $display("FAIL ovf_e1: got {%h,%0d} want {11,5}", rd_data, rd_ts); end
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL ovf_tick19: got %b want 1", tick); end
    step(1);
    total++; if (rd_data !== 8'h22 || rd_ts !== 16'd8) begin bad++; $display("FAIL ovf_e2: got {%h,%0d} want {22,8}", rd_data, rd_ts); end
    step(1);
    total++; if (rd_data !== 8'h33 || rd_ts !== 16'd11) begin bad++; $display("FAIL ovf_e3: got {%h,%0d} want {33,11}", rd_data, rd_ts); end
    step(1);
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h55 || rd_ts !== 16'd18) begin bad++; $display("FAIL ovf_retry: got %b {%h,%0d} want 1 {55,18}", rd_valid, rd_data, rd_ts); end
    step(1);
    rd_ready = 1'b0;
    total++; if (rd_valid !== 1'b0 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_end: got valid=%b ovf=%b want 0 1", rd_valid, overflow); end
  endtask

  task automatic test_ticks_done();
    do_start();                       // mon_in is 55
    total++; if (overflow !== 1'b0 || intervals !== 2'd0) begin bad++; $display("FAIL run_clear: got ovf=%b iv=%0d want 0 0", overflow, intervals); end
    step_to(18);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL tick18: got %b want 0", tick); end
    step(1);
    total++; if (tick !== 1'b1 || intervals !== 2'd0) begin bad++; $display("FAIL tick19: got %b iv=%0d want 1 0", tick, intervals); end
    step(1);
    total++; if (tick !== 1'b0 || intervals !== 2'd1) begin bad++; $display("FAIL tick20: got %b iv=%0d want 0 1", tick, intervals); end
    step_to(39);
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL tick39: got %b want 1", tick); end
    step(1);
    total++; if (intervals !== 2'd2) begin bad++; $display("FAIL iv40: got %0d want 2", intervals); end
    step_to(57); mon_in = 8'h77;      // settles into a push on the final tick cycle
    step_to(59);
    total++; if (tick !== 1'b1 || running !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL tick59: got tick=%b run=%b done=%b want 1 1 0", tick, running, done); end
    step(1);
    total++; if (done !== 1'b1 || running !== 1'b0 || tick !== 1'b0 || intervals !== 2'd3) begin bad++; $display("FAIL done60: got done=%b run=%b tick=%b iv=%0d want 1 0 0 3", done, running, tick, intervals); end
    mon_in = 8'h66;
    step_to(66);
    total++; if (done !== 1'b1 || tick !== 1'b0 || intervals !== 2'd3) begin bad++; $display("FAIL done66: got done=%b tick=%b iv=%0d want 1 0 3", done, tick, intervals); end
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h55 || rd_ts !== 16'd2) begin bad++; $display("FAIL drain_e0: got %b {%h,%0d} want 1 {55,2}", rd_valid, rd_data, rd_ts); end
    rd_ready = 1'b1;
    step(1);
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h77 || rd_ts !== 16'd59) begin bad++; $display("FAIL drain_final: got %b {%h,%0d} want 1 {77,59}", rd_valid, rd_data, rd_ts); end
    step(1);
    rd_ready = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got valid=%b data=%h want 0", rd_valid, rd_data); end
  endtask

  task automatic test_restart();
    do_start();                       // from DONE, mon_in is 66
    step_to(3); mon_in = 8'h88;
    step_to(7);
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h66 || rd_ts !== 16'd2) begin bad++; $display("FAIL rs_pre: got %b {%h,%0d} want 1 {66,2}", rd_valid, rd_data, rd_ts); end
    start = 1'b1; rd_ready = 1'b1;    // start and pop together: start wins
    step(1);
    start = 1'b0; rd_ready = 1'b0; t = 0;
    total++; if (rd_valid !== 1'b0 || running !== 1'b1 || intervals !== 2'd0) begin bad++; $display("FAIL rs_flush: got valid=%b run=%b iv=%0d want 0 1 0", rd_valid, running, intervals); end
    step_to(3);
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h88 || rd_ts !== 16'd2) begin bad++; $display("FAIL rs_first: got %b {%h,%0d} want 1 {88,2}", rd_valid, rd_data, rd_ts); end
  endtask

  task automatic test_reset_midrun();
    step(2);
    resetn = 1'b0;
    #1;
    total++; if ({rd_valid, tick, running, done, overflow} !== 5'b0 || intervals !== 2'd0) begin bad++; $display("FAIL mr_flags: got %b iv=%0d want 00000 0", {rd_valid, tick, running, done, overflow}, intervals); end
    total++; if (rd_data !== 8'h00 || rd_ts !== 16'h0) begin bad++; $display("FAIL mr_rd: got %h/%h want 00/0000", rd_data, rd_ts); end
    step(1);
    resetn = 1'b1;
    mon_in = 8'h99;
    step(4);
    total++; if (running !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL mr_idle: got run=%b done=%b valid=%b want 0 0 0", running, done, rd_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_initial_value();
    test_change_glitch();
    test_overflow();
    test_ticks_done();
    test_restart();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
